// File: rtl/c6288_multiplier_if.sv
// Operand/product bundle for the c6288 multiplier; the vector source drives
// a/b and the logger samples p.
interface c6288_multiplier_if;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] p;

  modport master (output a, output b, input p);
  modport slave (input a, input b, output p);
endinterface

// File: rtl/c6288_multiplier.sv
// Registered 16x16 unsigned array multiplier with the ISCAS-85 c6288 port set.
// Half/full-adder ripple rows reduce the partial products; prod_q holds P.
module c6288_multiplier (
  input  logic clk,
  input  logic rst,
  input  logic N1,
  input  logic N18,
  input  logic N35,
  input  logic N52,
  input  logic N69,
  input  logic N86,
  input  logic N103,
  input  logic N120,
  input  logic N137,
  input  logic N154,
  input  logic N171,
  input  logic N188,
  input  logic N205,
  input  logic N222,
  input  logic N239,
  input  logic N256,
  input  logic N273,
  input  logic N290,
  input  logic N307,
  input  logic N324,
  input  logic N341,
  input  logic N358,
  input  logic N375,
  input  logic N392,
  input  logic N409,
  input  logic N426,
  input  logic N443,
  input  logic N460,
  input  logic N477,
  input  logic N494,
  input  logic N511,
  input  logic N528,
  output logic N545,
  output logic N1581,
  output logic N1901,
  output logic N2223,
  output logic N2548,
  output logic N2877,
  output logic N3211,
  output logic N3552,
  output logic N3895,
  output logic N4241,
  output logic N4591,
  output logic N4946,
  output logic N5308,
  output logic N5672,
  output logic N5971,
  output logic N6123,
  output logic N6150,
  output logic N6160,
  output logic N6170,
  output logic N6180,
  output logic N6190,
  output logic N6200,
  output logic N6210,
  output logic N6220,
  output logic N6230,
  output logic N6240,
  output logic N6250,
  output logic N6260,
  output logic N6270,
  output logic N6280,
  output logic N6287,
  output logic N6288
);

  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] pp [0:15];
  logic [15:0] rs [0:15];
  logic [15:0] rc [1:15];
  logic [31:0] prod_d;
  logic [31:0] prod_q;

  assign a = {N256, N239, N222, N205, N188, N171, N154, N137,
              N120, N103, N86,  N69,  N52,  N35,  N18,  N1};
  assign b = {N528, N511, N494, N477, N460, N443, N426, N409,
              N392, N375, N358, N341, N324, N307, N290, N273};

  for (genvar i = 0; i < 16; i++) begin : g_pp
    assign pp[i] = a & {16{b[i]}};
  end

  assign rs[0] = pp[0];

  // Row i adds pp[i] to the previous row sum shifted right by one, with the
  // previous row's carry-out entering as the new MSB.
  for (genvar i = 1; i < 16; i++) begin : g_row
    logic [15:0] acc;
    if (i == 1) begin : g_first
      assign acc = {1'b0, rs[0][15:1]};
    end else begin : g_next
      assign acc = {rc[i-1][15], rs[i-1][15:1]};
    end

    for (genvar j = 0; j < 16; j++) begin : g_cell
      if (j == 0) begin : g_ha
        assign rs[i][j] = pp[i][j] ^ acc[j];
        assign rc[i][j] = pp[i][j] & acc[j];
      end else begin : g_fa
        logic hs;
        assign hs       = pp[i][j] ^ acc[j];
        assign rs[i][j] = hs ^ rc[i][j-1];
        assign rc[i][j] = (pp[i][j] & acc[j]) | (hs & rc[i][j-1]);
      end
    end
  end

  always_comb begin
    prod_d = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      prod_d[k] = rs[k][0];
    end
    prod_d[31:16] = {rc[15][15], rs[15][15:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  assign N545  = prod_q[0];
  assign N1581 = prod_q[1];
  assign N1901 = prod_q[2];
  assign N2223 = prod_q[3];
  assign N2548 = prod_q[4];
  assign N2877 = prod_q[5];
  assign N3211 = prod_q[6];
  assign N3552 = prod_q[7];
  assign N3895 = prod_q[8];
  assign N4241 = prod_q[9];
  assign N4591 = prod_q[10];
  assign N4946 = prod_q[11];
  assign N5308 = prod_q[12];
  assign N5672 = prod_q[13];
  assign N5971 = prod_q[14];
  assign N6123 = prod_q[15];
  assign N6150 = prod_q[16];
  assign N6160 = prod_q[17];
  assign N6170 = prod_q[18];
  assign N6180 = prod_q[19];
  assign N6190 = prod_q[20];
  assign N6200 = prod_q[21];
  assign N6210 = prod_q[22];
  assign N6220 = prod_q[23];
  assign N6230 = prod_q[24];
  assign N6240 = prod_q[25];
  assign N6250 = prod_q[26];
  assign N6260 = prod_q[27];
  assign N6270 = prod_q[28];
  assign N6280 = prod_q[29];
  assign N6287 = prod_q[30];
  assign N6288 = prod_q[31];

endmodule

// File: tb/tb_c6288_multiplier.sv
// Bench for c6288_multiplier: directed, back-to-back, async-reset and random
// products checked against A*B through an expected-value queue.
module tb_c6288_multiplier;
  logic clk;
  logic rst;
  logic [31:0] dut_p;
  logic [31:0] sb_q [$];
  int total;
  int bad;

  c6288_multiplier_if bus ();

  assign bus.p = dut_p;

  c6288_multiplier dut (
    .clk  (clk),
    .rst  (rst),
    .N1   (bus.a[0]),  .N18  (bus.a[1]),  .N35  (bus.a[2]),  .N52  (bus.a[3]),
    .N69  (bus.a[4]),  .N86  (bus.a[5]),  .N103 (bus.a[6]),  .N120 (bus.a[7]),
    .N137 (bus.a[8]),  .N154 (bus.a[9]),  .N171 (bus.a[10]), .N188 (bus.a[11]),
    .N205 (bus.a[12]), .N222 (bus.a[13]), .N239 (bus.a[14]), .N256 (bus.a[15]),
    .N273 (bus.b[0]),  .N290 (bus.b[1]),  .N307 (bus.b[2]),  .N324 (bus.b[3]),
    .N341 (bus.b[4]),  .N358 (bus.b[5]),  .N375 (bus.b[6]),  .N392 (bus.b[7]),
    .N409 (bus.b[8]),  .N426 (bus.b[9]),  .N443 (bus.b[10]), .N460 (bus.b[11]),
    .N477 (bus.b[12]), .N494 (bus.b[13]), .N511 (bus.b[14]), .N528 (bus.b[15]),
    .N545  (dut_p[0]),  .N1581 (dut_p[1]),  .N1901 (dut_p[2]),  .N2223 (dut_p[3]),
    .N2548 (dut_p[4]),  .N2877 (dut_p[5]),  .N3211 (dut_p[6]),  .N3552 (dut_p[7]),
    .N3895 (dut_p[8]),  .N4241 (dut_p[9]),  .N4591 (dut_p[10]), .N4946 (dut_p[11]),
    .N5308 (dut_p[12]), .N5672 (dut_p[13]), .N5971 (dut_p[14]), .N6123 (dut_p[15]),
    .N6150 (dut_p[16]), .N6160 (dut_p[17]), .N6170 (dut_p[18]), .N6180 (dut_p[19]),
    .N6190 (dut_p[20]), .N6200 (dut_p[21]), .N6210 (dut_p[22]), .N6220 (dut_p[23]),
    .N6230 (dut_p[24]), .N6240 (dut_p[25]), .N6250 (dut_p[26]), .N6260 (dut_p[27]),
    .N6270 (dut_p[28]), .N6280 (dut_p[29]), .N6287 (dut_p[30]), .N6288 (dut_p[31])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    logic [31:0] exp;
    rst   = 1'b1;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    #1;
    total++;
    if (dut_p !== 32'h0) begin
      bad++;
      $display("FAIL reset_immediate: got %h want %h", dut_p, 32'h0);
    end
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (dut_p !== 32'h0) begin
        bad++;
        $display("FAIL reset_hold: got %h want %h", dut_p, 32'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    sb_q.push_back(32'hFFFE0001);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    total++;
    if (dut_p !== exp) begin
      bad++;
      $display("FAIL reset_release: got %h want %h", dut_p, exp);
    end
  endtask

  task automatic test_directed();
    logic [15:0] av [6] = '{16'h0000, 16'h0001, 16'hBEEF, 16'h1234, 16'h8000, 16'h8000};
    logic [15:0] bv [6] = '{16'hBEEF, 16'hBEEF, 16'h0001, 16'h5678, 16'h0002, 16'h8000};
    logic [31:0] ev [6] = '{32'h00000000, 32'h0000BEEF, 32'h0000BEEF,
                            32'h06260060, 32'h00010000, 32'h40000000};
    logic [31:0] exp;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.a = av[i];
      bus.b = bv[i];
      sb_q.push_back(ev[i]);
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      total++;
      if (dut_p !== exp) begin
        bad++;
        $display("FAIL directed[%0d] %h*%h: got %h want %h", i, av[i], bv[i], dut_p, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] av [8] = '{16'h0003, 16'h00FF, 16'hFFFF, 16'h0000,
                            16'h7FFF, 16'hA5A5, 16'h0010, 16'hFFFF};
    logic [15:0] bv [8] = '{16'h0005, 16'h0101, 16'h0002, 16'h1234,
                            16'h7FFF, 16'h5A5A, 16'h0100, 16'hFFFF};
    logic [31:0] exp;
    logic [31:0] prev;
    prev = dut_p;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.a = av[i];
      bus.b = bv[i];
      sb_q.push_back(32'(av[i]) * 32'(bv[i]));
      #1;
      total++;
      if (dut_p !== prev) begin
        bad++;
        $display("FAIL b2b_hold[%0d]: got %h want %h", i, dut_p, prev);
      end
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      total++;
      if (dut_p !== exp) begin
        bad++;
        $display("FAIL b2b[%0d]: got %h want %h", i, dut_p, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp;
    @(negedge clk);
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    sb_q.push_back(32'hFFFE0001);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    total++;
    if (dut_p !== exp) begin
      bad++;
      $display("FAIL async_pre: got %h want %h", dut_p, exp);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (dut_p !== 32'h0) begin
      bad++;
      $display("FAIL async_clear: got %h want %h", dut_p, 32'h0);
    end
    @(posedge clk); #1;
    total++;
    if (dut_p !== 32'h0) begin
      bad++;
      $display("FAIL async_hold: got %h want %h", dut_p, 32'h0);
    end
    @(negedge clk);
    rst   = 1'b0;
    bus.a = 16'h0102;
    bus.b = 16'h0304;
    sb_q.push_back(32'h00030A08);
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    total++;
    if (dut_p !== exp) begin
      bad++;
      $display("FAIL async_release: got %h want %h", dut_p, exp);
    end
  endtask

  task automatic test_walking_ones();
    logic [31:0] exp;
    logic [15:0] other;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      other = 16'($urandom);
      if (i < 16) begin
        bus.a = 16'h1 << i;
        bus.b = other;
      end else begin
        bus.a = other;
        bus.b = 16'h1 << (i - 16);
      end
      sb_q.push_back(32'(bus.a) * 32'(bus.b));
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      total++;
      if (dut_p !== exp) begin
        bad++;
        $display("FAIL walk[%0d] %h*%h: got %h want %h", i, bus.a, bus.b, dut_p, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic [15:0] ra;
    logic [15:0] rb;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ra = 16'($urandom);
      rb = 16'($urandom);
      bus.a = ra;
      bus.b = rb;
      sb_q.push_back(32'(ra) * 32'(rb));
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      total++;
      if (dut_p !== exp) begin
        bad++;
        $display("FAIL random[%0d] %h*%h: got %h want %h", i, ra, rb, dut_p, exp);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_walking_ones();
    test_random();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d want %0d", sb_q.size(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
